pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit_pkg.sv | 17 +
 rtl/pipeline_hazard_unit_forward_select.sv | 31 +++
 rtl/pipeline_hazard_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Purpose: shared types and constants for the pipeline hazard unit.
// Holds the memory-wait FSM state enum, forwarding selects and the load encoding.
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_unit_forward_select.sv
// Purpose: operand forwarding select for one execute-stage source register.
// Ports: i_rs (E source), i_rd_m/i_rd_w + write enables, o_fwd (FWD_* select).
module forward_select
    import pipeline_hazard_unit_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hardwired, so a write to it must never be forwarded
    assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

    // M holds the younger result, so it wins over W
    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m) begin
            o_fwd = FWD_M;
        end else if (w_hit_w) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Purpose: RISC-V pipeline hazard unit: forwarding, load-use stall, branch
// flush and data-memory wait/timeout FSM.
// Ports: clk, rst (sync, active-high); register ids Rs1D/Rs2D/Rs1E/Rs2E/RDE/
// RDM/RDW; RegWriteM/W, ResultSrcE, PCSrcE, MemReqM/MemAckM in;
// StallF/D/E/M, FlushD/E/W, ForwardAE/BE, MemErr out.
// Optional: HAZARD_PERF_CNT_EN adds saturating StallCnt/FlushCnt outputs.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RDE,
    input  logic [4:0]       RDM,
    input  logic [4:0]       RDW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         r_state;
    hz_state_e         w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_mem_stall;
    logic              w_lwstall;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    forward_select u_fwd_a (
        .i_rs          (Rs1E),
        .i_rd_m        (RDM),
        .i_rd_w        (RDW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    forward_select u_fwd_b (
        .i_rs          (Rs2E),
        .i_rd_m        (RDM),
        .i_rd_w        (RDW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    assign w_lwstall = (ResultSrcE == RES_SRC_LOAD) && (RDE != 5'd0)
                    && ((RDE == Rs1D) || (RDE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // The stall is asserted in the request cycle itself, so the M-stage
    // instruction never advances past an unacknowledged access.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_mem_stall = 1'b0;
        case (r_state)
            RUN: begin
                if (MemReqM && !MemAckM) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemAckM) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        w_state_nxt = MEM_ERR;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end
            end
            MEM_ERR: begin
                w_mem_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Priority: reset, memory wait, branch flush, load-use stall
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lwstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign ForwardAE = rst ? FWD_RF : w_fwd_a;
    assign ForwardBE = rst ? FWD_RF : w_fwd_b;
    assign MemErr    = (r_state == MEM_ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (FlushE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule
